// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package cv32e40p_pkg;

  // Which source drives register-file write port B in a given cycle.
  typedef enum logic [1:0] {
    WB_SRC_LSU  = 2'd0,
    WB_SRC_FIFO = 2'd1,
    WB_SRC_APU  = 2'd2,
    WB_SRC_NONE = 2'd3
  } wb_src_e;

  // Integer register x0 is hard-wired to zero; writes to it are dropped.
  // Address 32 (f0, FP bank selected by the top address bit) stays writable.
  localparam int unsigned RF_X0_ADDR = 0;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must be able to hold the value 'depth'.
  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_wb_arbiter_if.sv
// Bundle of writeback sources, register-file write ports and status flags.
//
// Handshake rules:
//   ex_* and lsu_* are fire-and-forget: a write is presented for exactly the
//   cycle its *_we_i is high and is never back-pressured.
//   apu_* uses valid/ready: a result transfers on every rising clock edge
//   where apu_valid_i and apu_ready_o are both high. While apu_valid_i is high
//   and apu_ready_o low, the producer must hold apu_waddr_i/apu_wdata_i stable.
//   apu_ready_o may depend combinationally on lsu_we_i in the same cycle.
interface cv32e40p_rf_wb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  // EX-stage writeback
  logic                  ex_we_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;
  // Load result
  logic                  lsu_we_i;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  // APU result
  logic                  apu_valid_i;
  logic [ADDR_WIDTH-1:0] apu_waddr_i;
  logic [DATA_WIDTH-1:0] apu_wdata_i;
  logic                  apu_ready_o;
  // Register file write port A
  logic                  we_a_o;
  logic [ADDR_WIDTH-1:0] waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  // Register file write port B
  logic                  we_b_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  // Status
  logic                  apu_pending_o;
  logic                  waw_collision_o;

  // Pipeline side: drives the sources, observes the ports.
  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output apu_valid_i, apu_waddr_i, apu_wdata_i,
    input  apu_ready_o,
    input  we_a_o, waddr_a_o, wdata_a_o,
    input  we_b_o, waddr_b_o, wdata_b_o,
    input  apu_pending_o, waw_collision_o
  );

  // Arbiter side.
  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  apu_valid_i, apu_waddr_i, apu_wdata_i,
    output apu_ready_o,
    output we_a_o, waddr_a_o, wdata_a_o,
    output we_b_o, waddr_b_o, wdata_b_o,
    output apu_pending_o, waw_collision_o
  );

endinterface

// File: rtl/cv32e40p_fifo.sv
// Small synchronous FIFO with asynchronous clear; simultaneous push and pop
// are allowed even when full (the popped slot is reused by the push).
module cv32e40p_fifo
  import cv32e40p_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 38,
  parameter  int unsigned DEPTH      = 2,
  localparam int unsigned PTR_W      = fifo_ptr_width(DEPTH),
  localparam int unsigned CNT_W      = fifo_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_push, do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values from this cycle's push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Register-file writeback arbiter: EX owns port A, LSU/APU share port B with
// a skid buffer absorbing APU results that lose arbitration.
module cv32e40p_rf_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned APU_FIFO_DEPTH = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  cv32e40p_rf_wb_arbiter_if.slave bus
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = fifo_cnt_width(APU_FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] X0_ADDR = ADDR_WIDTH'(RF_X0_ADDR);

  wb_src_e               src_b;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  apu_ready;
  logic                  we_b_raw;
  logic [ADDR_WIDTH-1:0] waddr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  we_b;
  logic                  we_a;
  logic                  collision_d;
  logic                  collision_q;

  // Port B source: loads are never stalled, then buffered APU results in
  // order, and only with an empty buffer may a fresh APU result go straight
  // through.
  always_comb begin
    src_b = WB_SRC_NONE;
    if (bus.lsu_we_i) begin
      src_b = WB_SRC_LSU;
    end else if (!fifo_empty) begin
      src_b = WB_SRC_FIFO;
    end else if (bus.apu_valid_i) begin
      src_b = WB_SRC_APU;
    end
  end

  // Port B data path; address/data follow the selected source even when the
  // write enable ends up gated.
  always_comb begin
    we_b_raw = 1'b1;
    waddr_b  = bus.apu_waddr_i;
    wdata_b  = bus.apu_wdata_i;
    case (src_b)
      WB_SRC_LSU: begin
        waddr_b = bus.lsu_waddr_i;
        wdata_b = bus.lsu_wdata_i;
      end
      WB_SRC_FIFO: begin
        {waddr_b, wdata_b} = fifo_rdata;
      end
      WB_SRC_APU: begin
        waddr_b = bus.apu_waddr_i;
        wdata_b = bus.apu_wdata_i;
      end
      default: begin
        we_b_raw = 1'b0;
      end
    endcase
  end

  // Skid-buffer control: drain whenever port B is free of loads; accept a
  // new APU result if there is room now or the head leaves this cycle.
  always_comb begin
    fifo_pop   = (src_b == WB_SRC_FIFO);
    apu_ready  = !fifo_full || fifo_pop;
    fifo_push  = bus.apu_valid_i && apu_ready && (src_b != WB_SRC_APU);
    fifo_wdata = {bus.apu_waddr_i, bus.apu_wdata_i};
  end

  // Write enables: x0 writes are dropped, and when both ports hit the same
  // register the port-B write (the later result) wins.
  always_comb begin
    we_b        = we_b_raw && (waddr_b != X0_ADDR);
    collision_d = bus.ex_we_i && (bus.ex_waddr_i != X0_ADDR) &&
                  we_b && (waddr_b == bus.ex_waddr_i);
    we_a        = bus.ex_we_i && (bus.ex_waddr_i != X0_ADDR) && !collision_d;
  end

  // Collision flag: one-cycle registered pulse after the dropped port-A write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  cv32e40p_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (APU_FIFO_DEPTH)
  ) u_apu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign bus.we_a_o          = we_a;
  assign bus.waddr_a_o       = bus.ex_waddr_i;
  assign bus.wdata_a_o       = bus.ex_wdata_i;
  assign bus.we_b_o          = we_b;
  assign bus.waddr_b_o       = waddr_b;
  assign bus.wdata_b_o       = wdata_b;
  assign bus.apu_ready_o     = apu_ready;
  assign bus.apu_pending_o   = (fifo_cnt != '0);
  assign bus.waw_collision_o = collision_q;

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter with a queue-based reference model.
module tb_cv32e40p_rf_wb_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;

  cv32e40p_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cv32e40p_rf_wb_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .APU_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required end before 200000");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [AW+DW-1:0] exp_q[$];
  bit               nxt_pop;
  bit               nxt_push;
  bit               nxt_coll;
  bit               exp_coll;
  logic [AW+DW-1:0] nxt_entry;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle when all inputs are settled.
  always @(negedge clk) begin : model_cmp
    bit               has_b;
    bit               exp_we_b;
    bit               exp_we_a;
    bit               exp_ready;
    bit               coll_now;
    bit               direct;
    logic [AW-1:0]    b_addr;
    logic [DW-1:0]    b_data;
    if (chk_en) begin
      has_b  = 1'b1;
      b_addr = bus.apu_waddr_i;
      b_data = bus.apu_wdata_i;
      if (bus.lsu_we_i) begin
        b_addr = bus.lsu_waddr_i;
        b_data = bus.lsu_wdata_i;
      end else if (exp_q.size() != 0) begin
        {b_addr, b_data} = exp_q[0];
      end else if (!bus.apu_valid_i) begin
        has_b = 1'b0;
      end
      direct    = !bus.lsu_we_i && (exp_q.size() == 0);
      exp_ready = (exp_q.size() < DEPTH) || (!bus.lsu_we_i && exp_q.size() > 0);
      exp_we_b  = has_b && (b_addr != 0);
      coll_now  = bus.ex_we_i && (bus.ex_waddr_i != 0) && exp_we_b && (b_addr == bus.ex_waddr_i);
      exp_we_a  = bus.ex_we_i && (bus.ex_waddr_i != 0) && !coll_now;

      chk("we_a", 64'(bus.we_a_o), 64'(exp_we_a));
      chk("waddr_a", 64'(bus.waddr_a_o), 64'(bus.ex_waddr_i));
      chk("wdata_a", 64'(bus.wdata_a_o), 64'(bus.ex_wdata_i));
      chk("we_b", 64'(bus.we_b_o), 64'(exp_we_b));
      if (has_b) begin
        chk("waddr_b", 64'(bus.waddr_b_o), 64'(b_addr));
        chk("wdata_b", 64'(bus.wdata_b_o), 64'(b_data));
      end
      chk("apu_ready", 64'(bus.apu_ready_o), 64'(exp_ready));
      chk("apu_pending", 64'(bus.apu_pending_o), 64'(exp_q.size() != 0));
      chk("waw_collision", 64'(bus.waw_collision_o), 64'(exp_coll));

      nxt_pop   = !bus.lsu_we_i && (exp_q.size() != 0);
      nxt_push  = bus.apu_valid_i && exp_ready && !direct;
      nxt_entry = {bus.apu_waddr_i, bus.apu_wdata_i};
      nxt_coll  = coll_now;
      if (!rst_n) begin
        nxt_pop  = 1'b0;
        nxt_push = 1'b0;
        nxt_coll = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (nxt_pop) void'(exp_q.pop_front());
      if (nxt_push) exp_q.push_back(nxt_entry);
      exp_coll = nxt_coll;
      nxt_pop  = 1'b0;
      nxt_push = 1'b0;
      nxt_coll = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    nxt_pop  = 1'b0;
    nxt_push = 1'b0;
    nxt_coll = 1'b0;
    exp_coll = 1'b0;
  end

  // ---------------- driver ----------------
  task automatic drive(input bit exw, input int exa, input logic [DW-1:0] exd,
                       input bit lw, input int la, input logic [DW-1:0] ld,
                       input bit av, input int aa, input logic [DW-1:0] ad);
    @(posedge clk);
    #1;
    bus.ex_we_i     = exw;
    bus.ex_waddr_i  = AW'(exa);
    bus.ex_wdata_i  = exd;
    bus.lsu_we_i    = lw;
    bus.lsu_waddr_i = AW'(la);
    bus.lsu_wdata_i = ld;
    bus.apu_valid_i = av;
    bus.apu_waddr_i = AW'(aa);
    bus.apu_wdata_i = ad;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0, 0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit held;
    int la;
    int aa;
    rst_n           = 1'b0;
    bus.ex_we_i     = 1'b1;
    bus.ex_waddr_i  = AW'(3);
    bus.ex_wdata_i  = 32'h1234;
    bus.lsu_we_i    = 1'b0;
    bus.lsu_waddr_i = '0;
    bus.lsu_wdata_i = '0;
    bus.apu_valid_i = 1'b0;
    bus.apu_waddr_i = '0;
    bus.apu_wdata_i = '0;
    chk_en          = 1'b1;
    #3;
    // Reset values; port A still follows EX.
    chk("rst_pending", 64'(bus.apu_pending_o), 64'd0);
    chk("rst_coll", 64'(bus.waw_collision_o), 64'd0);
    chk("rst_ready", 64'(bus.apu_ready_o), 64'd1);
    chk("rst_we_a", 64'(bus.we_a_o), 64'd1);
    chk("rst_we_b", 64'(bus.we_b_o), 64'd0);
    #9;
    rst_n = 1'b1;

    // EX straight to port A.
    drive(1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, '0);
    chk("ex_we_a", 64'(bus.we_a_o), 64'd1);
    chk("ex_waddr_a", 64'(bus.waddr_a_o), 64'd5);
    chk("ex_wdata_a", 64'(bus.wdata_a_o), 64'hDEADBEEF);

    // LSU wins port B, APU result buffered and drained next cycle.
    drive(0, 0, '0, 1, 7, 32'h77, 1, 9, 32'h11);
    chk("lsu_apu_we_b", 64'(bus.we_b_o), 64'd1);
    chk("lsu_apu_waddr_b", 64'(bus.waddr_b_o), 64'd7);
    chk("lsu_apu_ready", 64'(bus.apu_ready_o), 64'd1);
    idle();
    chk("drain_pending", 64'(bus.apu_pending_o), 64'd1);
    chk("drain_waddr_b", 64'(bus.waddr_b_o), 64'd9);
    chk("drain_wdata_b", 64'(bus.wdata_b_o), 64'h11);
    idle();
    chk("drained_pending", 64'(bus.apu_pending_o), 64'd0);
    chk("drained_we_b", 64'(bus.we_b_o), 64'd0);

    // Three LSU cycles fill the buffer; third APU result back-pressured.
    drive(0, 0, '0, 1, 1, 32'h100, 1, 20, 32'hA0);
    chk("fill1_ready", 64'(bus.apu_ready_o), 64'd1);
    drive(0, 0, '0, 1, 2, 32'h200, 1, 21, 32'hA1);
    chk("fill2_ready", 64'(bus.apu_ready_o), 64'd1);
    drive(0, 0, '0, 1, 3, 32'h300, 1, 22, 32'hA2);
    chk("fill3_ready", 64'(bus.apu_ready_o), 64'd0);
    chk("fill3_waddr_b", 64'(bus.waddr_b_o), 64'd3);
    drive(0, 0, '0, 0, 0, '0, 1, 22, 32'hA2);
    chk("full_drain_ready", 64'(bus.apu_ready_o), 64'd1);
    chk("order1_waddr_b", 64'(bus.waddr_b_o), 64'd20);
    chk("order1_wdata_b", 64'(bus.wdata_b_o), 64'hA0);
    idle();
    chk("order2_waddr_b", 64'(bus.waddr_b_o), 64'd21);
    idle();
    chk("order3_waddr_b", 64'(bus.waddr_b_o), 64'd22);
    chk("order3_wdata_b", 64'(bus.wdata_b_o), 64'hA2);
    idle();
    chk("order_done_we_b", 64'(bus.we_b_o), 64'd0);

    // Same-address collision: port A dropped, pulse one cycle later.
    drive(1, 12, 32'h55, 1, 12, 32'h66, 0, 0, '0);
    chk("coll_we_a", 64'(bus.we_a_o), 64'd0);
    chk("coll_we_b", 64'(bus.we_b_o), 64'd1);
    chk("coll_waddr_a", 64'(bus.waddr_a_o), 64'd12);
    chk("coll_flag_now", 64'(bus.waw_collision_o), 64'd0);
    idle();
    chk("coll_flag_next", 64'(bus.waw_collision_o), 64'd1);
    idle();
    chk("coll_flag_after", 64'(bus.waw_collision_o), 64'd0);

    // x0 gated, f0 writable.
    drive(1, 0, 32'h77, 0, 0, '0, 0, 0, '0);
    chk("x0_we_a", 64'(bus.we_a_o), 64'd0);
    chk("x0_wdata_a", 64'(bus.wdata_a_o), 64'h77);
    drive(0, 0, '0, 0, 0, '0, 1, 32, 32'hF0);
    chk("f0_we_b", 64'(bus.we_b_o), 64'd1);
    chk("f0_waddr_b", 64'(bus.waddr_b_o), 64'd32);
    drive(1, 0, 32'h1, 0, 0, '0, 1, 0, 32'h2);
    chk("x0_we_b", 64'(bus.we_b_o), 64'd0);
    chk("x0_apu_ready", 64'(bus.apu_ready_o), 64'd1);
    drive(1, 32, 32'h3, 1, 32, 32'h4, 0, 0, '0);
    chk("f0_coll_we_a", 64'(bus.we_a_o), 64'd0);
    idle();
    chk("f0_coll_flag", 64'(bus.waw_collision_o), 64'd1);
    drive(1, 9, 32'h5, 0, 0, '0, 1, 9, 32'h6);
    chk("apu_coll_we_a", 64'(bus.we_a_o), 64'd0);
    idle();

    // Mixed traffic checked by the model; APU producer holds until accepted.
    held = 1'b0;
    for (int i = 0; i < 60; i++) begin
      la = ($urandom_range(0, 5) == 0) ? 32 : int'($urandom_range(0, 7));
      aa = ($urandom_range(0, 5) == 0) ? 32 : int'($urandom_range(0, 7));
      if (held) begin
        drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 1), la, $urandom,
              1, int'(bus.apu_waddr_i), bus.apu_wdata_i);
      end else begin
        drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 1), la, $urandom,
              $urandom_range(0, 1), aa, $urandom);
      end
      held = bus.apu_valid_i && !bus.apu_ready_o;
    end
    for (int i = 0; i < 4; i++) idle();
    chk("mix_drained", 64'(bus.apu_pending_o), 64'd0);

    // Reset mid-drain discards buffered results.
    drive(0, 0, '0, 1, 4, 32'h40, 1, 40, 32'hB0);
    drive(0, 0, '0, 1, 5, 32'h50, 1, 41, 32'hB1);
    idle();
    chk("rst_mid_pending_before", 64'(bus.apu_pending_o), 64'd1);
    chk("rst_mid_waddr_b", 64'(bus.waddr_b_o), 64'd40);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pending_async", 64'(bus.apu_pending_o), 64'd0);
    chk("rst_mid_we_b", 64'(bus.we_b_o), 64'd0);
    #1;
    rst_n = 1'b1;
    idle();
    chk("post_rst_we_b1", 64'(bus.we_b_o), 64'd0);
    idle();
    chk("post_rst_we_b2", 64'(bus.we_b_o), 64'd0);
    chk("post_rst_pending", 64'(bus.apu_pending_o), 64'd0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rf_wb_arbiter.md
CV32E40P_RF_WB_ARBITER -- requirements
Module: cv32e40p_rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, register address width (bit 5 selects FP bank).
REQ-002 Parameter DATA_WIDTH, default 32, write data width.
REQ-003 Parameter APU_FIFO_DEPTH, default 2, APU result skid-buffer entries.
REQ-004 clk  input  1  core clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ex_we_i / ex_waddr_i / ex_wdata_i  input  1 / ADDR_WIDTH / DATA_WIDTH  EX-stage writeback, fire-and-forget.
REQ-007 lsu_we_i / lsu_waddr_i / lsu_wdata_i  input  1 / ADDR_WIDTH / DATA_WIDTH  load result, fire-and-forget, never stalled.
REQ-008 apu_valid_i / apu_waddr_i / apu_wdata_i  input  1 / ADDR_WIDTH / DATA_WIDTH  APU result, valid/ready handshake.
REQ-009 apu_ready_o  output  1  APU result accepted this cycle when high with apu_valid_i.
REQ-010 we_a_o / waddr_a_o / wdata_a_o  output  1 / ADDR_WIDTH / DATA_WIDTH  register file write port A.
REQ-011 we_b_o / waddr_b_o / wdata_b_o  output  1 / ADDR_WIDTH / DATA_WIDTH  register file write port B.
REQ-012 apu_pending_o  output  1  skid buffer non-empty.
REQ-013 waw_collision_o  output  1  registered one-cycle pulse: port A write dropped by collision (REQ-021).

Function
REQ-014 Port A SHALL carry the EX writeback combinationally, zero latency.
REQ-015 Port B priority SHALL be: LSU > skid-buffer head > direct APU input.
REQ-016 APU result with empty buffer and no LSU write SHALL pass to port B same cycle; apu_ready_o high.
REQ-017 APU result arriving while LSU writes or buffer non-empty SHALL be enqueued if buffer not full.
REQ-018 apu_ready_o SHALL equal not-full, or full-and-draining-this-cycle (simultaneous push/pop allowed when full).
REQ-019 Buffer head SHALL drain to port B in any cycle without LSU write; strict FIFO order, no bypass past buffered entries.
REQ-020 Any write with address 0 (integer x0) SHALL force the corresponding we_*_o low; address 32 (f0) is a valid target.
REQ-021 If we_a and we_b target the same non-zero address in one cycle, we_a_o SHALL be deasserted and waw_collision_o pulse high next cycle.
REQ-022 Deasserted ports SHALL still drive waddr/wdata from their selected source; only we_*_o gates the write.
REQ-023 Buffer occupancy counter SHALL be clog2(APU_FIFO_DEPTH)+1 bits; read/write pointers wrap modulo depth.
REQ-024 apu_pending_o SHALL be high exactly while occupancy is non-zero.

Reset
REQ-025 Asserting rst_n low SHALL empty the buffer immediately, regardless of clock, discarding held results.
REQ-026 Reset values: apu_pending_o 0, waw_collision_o 0, apu_ready_o 1, we_a_o/we_b_o follow inputs per REQ-014/015.
REQ-027 Reset mid-drain SHALL produce no further port-B write from discarded entries after release.

Structure
REQ-028 Writeback source select enum (WB_SRC_LSU, WB_SRC_FIFO, WB_SRC_APU, WB_SRC_NONE) and the x0 address constant SHALL reside in cv32e40p_pkg.
REQ-029 Skid buffer SHALL be one instance of cv32e40p_fifo (DATA = ADDR_WIDTH+DATA_WIDTH, DEPTH = APU_FIFO_DEPTH); arbitration logic stays in this module.

Verification
REQ-030 ex_we=1, addr=5, data=0xDEADBEEF -> same cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF.
REQ-031 lsu_we=1 (addr 7) while apu_valid=1 (addr 9, 0x11) -> port B writes 7; APU enqueued; next cycle without LSU, port B writes 9/0x11; apu_pending_o 1 then 0.
REQ-032 LSU writes 3 consecutive cycles, APU valid each cycle -> 2 accepts, apu_ready_o low cycle 3; drains in order once LSU idle.
REQ-033 ex_we addr=12 and lsu_we addr=12 same cycle -> we_a_o=0, we_b_o=1, waw_collision_o=1 next cycle only.
REQ-034 ex_we addr=0 -> we_a_o=0; apu addr=32 -> we_b_o=1 (f0 writable).
REQ-035 Two entries buffered, rst_n pulsed low mid-cycle -> apu_pending_o 0 asynchronously, no port-B write after release.
